l2_req_arb: RTL
===============

Name: l2_req_arb

Overview:
- Two-client arbiter that shares the single L1-to-L2 request/response port of the unified L2 between the L1 instruction cache and the L1 data cache.
- Latches one winning request, presents it to the L2, and steers the L2 response back to the owning client.
- Sits between the two L1 caches and the L2. Only one transaction is outstanding at a time, matching the blocking L2.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 128, L1-side line-segment data width.
- CNT_W, 64, width of per-client grant counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- l1i_req_valid  in  1  I-side request
- l1i_req_addr  in  ADDR_W  I-side address
- l1i_req_opcode  in  4  I-side opcode (4 = load)
- l1i_req_ack  out  1  one-cycle accept pulse to I-side
- l1i_rsp_valid  out  1  response for I-side
- l1d_req_valid  in  1  D-side request
- l1d_req_addr  in  ADDR_W  D-side address
- l1d_req_opcode  in  4  D-side opcode (4 = load, 7 = store)
- l1d_req_store_data  in  DATA_W  D-side store data
- l1d_req_ack  out  1  one-cycle accept pulse to D-side
- l1d_rsp_valid  out  1  response for D-side
- l1_rsp_load_data  out  DATA_W  response data, fanned out to both clients
- l2_req_valid  out  1  request to L2
- l2_req_addr  out  ADDR_W  latched address
- l2_req_opcode  out  4  latched opcode
- l2_req_store_data  out  DATA_W  latched store data (zero for I-side)
- l2_req_ack  in  1  L2 accept pulse
- l2_rsp_valid  in  1  L2 response pulse
- l2_rsp_load_data  in  DATA_W  L2 response data
- owner_is_d  out  1  current or last owner (1 = D-side)
- spurious_rsp  out  1  sticky error flag
- grants_i, grants_d  out  CNT_W  grant counters

Behaviour:
- Reset values:
  - State IDLE.
  - All valid/ack outputs 0. Latched addr/opcode/data 0.
  - owner_is_d 0, priority pointer = D first.
  - spurious_rsp 0, counters 0.
- States: IDLE, ISSUE, WAIT_RSP.
- IDLE:
  - If any client valid, pick a winner.
  - Both valid: winner is the side the priority pointer names. Pointer then flips to the other side (round-robin). A single requester wins regardless of the pointer; the pointer still flips away from it.
  - On a win: latch addr/opcode, and store_data for D or 0 for I. Set owner_is_d. Register a client ack, visible next cycle for exactly one cycle. Increment the winner's grant counter (wraps). Set l2_req_valid=1 next cycle. Go to ISSUE.
- ISSUE:
  - l2_req_valid held 1 and request fields stable until l2_req_ack.
  - On l2_req_ack: l2_req_valid drops the next cycle.
  - If l2_rsp_valid is also high that cycle (L2 store completion), the response completes now; go to IDLE. Otherwise go to WAIT_RSP.
- WAIT_RSP: on l2_rsp_valid go to IDLE.
- Response routing is combinational, zero added latency:
  - l1i_rsp_valid = l2_rsp_valid & ~owner_is_d & (state ISSUE or WAIT_RSP); l1d_rsp_valid is the mirror.
  - l1_rsp_load_data = l2_rsp_load_data unconditionally.
- Client rules:
  - Hold valid and fields until the ack pulse; deassert the cycle after the ack.
  - The arbiter does not re-sample clients outside IDLE, so a held valid during ISSUE/WAIT_RSP is ignored.
  - Earliest re-grant is the cycle after returning to IDLE.
- spurious_rsp sets when l2_rsp_valid arrives in IDLE, or in ISSUE without l2_req_ack. It clears only on reset. The stray response is not forwarded.
- l2_rsp_valid in WAIT_RSP together with l2_req_ack: treated as the response; the ack is ignored.
- Reset mid-transaction:
  - Immediate return to IDLE, all valids/acks low, transaction abandoned.
  - The L2 is reset by the same signal.
- Minimum store turnaround:
  - Client valid at t, ack at t+1, l2_req_valid at t+1.
  - L2 ack+rsp at t+2, IDLE at t+3.

Test Plan:
- D store only: l1d valid, addr 0x1000, opcode 7, data 0xA5.. at t0 → l1d_req_ack at t0+1; l2_req_valid t0+1 with addr 0x1000 and data 0xA5..; l2 ack+rsp at t0+2 → l1d_rsp_valid pulse at t0+2; IDLE at t0+3; grants_d=1.
- I load with delayed rsp: opcode 4, addr 0x2040; L2 acks, rsp 10 cycles later with data 0x1234 → l1i_rsp_valid for 1 cycle with data 0x1234; l1d_rsp_valid stays 0.
- Simultaneous requests after reset: both valid continuously for 4 transactions → grant order D, I, D, I; grants_i=2, grants_d=2.
- I request arrives while D is outstanding in WAIT_RSP → no l1i_req_ack until after the D response; I is granted on the first IDLE cycle.
- Stray l2_rsp_valid in IDLE → no client rsp_valid; spurious_rsp=1 and stays set until reset.
- Reset asserted in WAIT_RSP → next cycle all outputs at reset values; a subsequent I-only request is acked normally.

Source files
------------

// File: rtl/l2_req_arb_if.sv
// L1/L2 request-response bundle shared by the two L1 clients and the L2.
// slave: arbiter view; master: environment (caches + L2) view.
interface l2_req_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
);
  logic              l1i_req_valid;
  logic [ADDR_W-1:0] l1i_req_addr;
  logic [3:0]        l1i_req_opcode;
  logic              l1i_req_ack;
  logic              l1i_rsp_valid;

  logic              l1d_req_valid;
  logic [ADDR_W-1:0] l1d_req_addr;
  logic [3:0]        l1d_req_opcode;
  logic [DATA_W-1:0] l1d_req_store_data;
  logic              l1d_req_ack;
  logic              l1d_rsp_valid;

  logic [DATA_W-1:0] l1_rsp_load_data;

  logic              l2_req_valid;
  logic [ADDR_W-1:0] l2_req_addr;
  logic [3:0]        l2_req_opcode;
  logic [DATA_W-1:0] l2_req_store_data;
  logic              l2_req_ack;
  logic              l2_rsp_valid;
  logic [DATA_W-1:0] l2_rsp_load_data;

  modport slave (
    input  l1i_req_valid, l1i_req_addr,
    input  l1i_req_opcode,
    output l1i_req_ack, l1i_rsp_valid,
    input  l1d_req_valid, l1d_req_addr,
    input  l1d_req_opcode, l1d_req_store_data,
    output l1d_req_ack, l1d_rsp_valid,
    output l1_rsp_load_data,
    output l2_req_valid, l2_req_addr,
    output l2_req_opcode, l2_req_store_data,
    input  l2_req_ack, l2_rsp_valid,
    input  l2_rsp_load_data
  );

  modport master (
    output l1i_req_valid, l1i_req_addr,
    output l1i_req_opcode,
    input  l1i_req_ack, l1i_rsp_valid,
    output l1d_req_valid, l1d_req_addr,
    output l1d_req_opcode, l1d_req_store_data,
    input  l1d_req_ack, l1d_rsp_valid,
    input  l1_rsp_load_data,
    input  l2_req_valid, l2_req_addr,
    input  l2_req_opcode, l2_req_store_data,
    output l2_req_ack, l2_rsp_valid,
    output l2_rsp_load_data
  );
endinterface

// File: rtl/l2_req_arb.sv
// Round-robin arbiter sharing the blocking L2 port between L1I and L1D.
// One transaction in flight; response steered to the latched owner.
module l2_req_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 64
) (
  input  logic             clk,
  input  logic             reset,
  l2_req_arb_if.slave      bus,
  output logic             owner_is_d,
  output logic             spurious_rsp,
  output logic [CNT_W-1:0] grants_i,
  output logic [CNT_W-1:0] grants_d
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP
  } state_t;

  state_t state, state_nx;

  logic              grant;
  logic              win_d;
  logic              rsp_ok;
  logic              stray;
  logic              ptr_d;
  logic              ack_i;
  logic              ack_d;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_opcode;
  logic [DATA_W-1:0] req_data;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    win_d    = 1'b0;
    rsp_ok   = 1'b0;
    stray    = 1'b0;
    unique case (state)
      IDLE: begin
        stray = bus.l2_rsp_valid;
        if (bus.l1i_req_valid | bus.l1d_req_valid) begin
          grant    = 1'b1;
          win_d    = bus.l1d_req_valid &
                     (ptr_d | ~bus.l1i_req_valid);
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        // a response without the accept is stray
        if (bus.l2_req_ack) begin
          rsp_ok   = bus.l2_rsp_valid;
          state_nx = bus.l2_rsp_valid ? IDLE : WAIT_RSP;
        end else begin
          stray = bus.l2_rsp_valid;
        end
      end
      WAIT_RSP: begin
        if (bus.l2_rsp_valid) begin
          rsp_ok   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_d        <= 1'b1;
      owner_is_d   <= 1'b0;
      ack_i        <= 1'b0;
      ack_d        <= 1'b0;
      req_valid    <= 1'b0;
      req_addr     <= '0;
      req_opcode   <= '0;
      req_data     <= '0;
      spurious_rsp <= 1'b0;
      grants_i     <= '0;
      grants_d     <= '0;
    end else begin
      ack_i <= grant & ~win_d;
      ack_d <= grant & win_d;
      if (grant) begin
        ptr_d      <= ~win_d;
        owner_is_d <= win_d;
        req_valid  <= 1'b1;
        if (win_d) begin
          req_addr   <= bus.l1d_req_addr;
          req_opcode <= bus.l1d_req_opcode;
          req_data   <= bus.l1d_req_store_data;
          grants_d   <= grants_d + 1'b1;
        end else begin
          req_addr   <= bus.l1i_req_addr;
          req_opcode <= bus.l1i_req_opcode;
          req_data   <= '0;
          grants_i   <= grants_i + 1'b1;
        end
      end else if (state == ISSUE && bus.l2_req_ack) begin
        req_valid <= 1'b0;
      end
      if (stray) spurious_rsp <= 1'b1;
    end
  end

  assign bus.l1i_req_ack       = ack_i;
  assign bus.l1d_req_ack       = ack_d;
  assign bus.l1i_rsp_valid     = rsp_ok & ~owner_is_d;
  assign bus.l1d_rsp_valid     = rsp_ok & owner_is_d;
  assign bus.l1_rsp_load_data  = bus.l2_rsp_load_data;
  assign bus.l2_req_valid      = req_valid;
  assign bus.l2_req_addr       = req_addr;
  assign bus.l2_req_opcode     = req_opcode;
  assign bus.l2_req_store_data = req_data;

endmodule
